ext_obi_rr_arbiter: RTL and testbench
=====================================

Name: ext_obi_rr_arbiter

Overview:
- Shares one external OBI slave port, e.g. the SimpleCnt window at EXT_SLAVE_START_ADDRESS, among NMaster OBI masters.
- Arbitration is round-robin. The winner is locked until the slave grants, so OBI address-phase stability holds.
- Granted master IDs are queued in order so that rvalid/rdata are routed back to the correct master.
- Sits between the masters and one slave port of the external OBI crossbar.

Parameters:
- NMaster, 2, number of requesting masters (>=2).
- MaxOutstanding, 2, maximum granted-but-unanswered transactions (>=1, power of 2).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- m_req_i  in  NMaster  per-master OBI req.
- m_gnt_o  out  NMaster  per-master OBI gnt.
- m_addr_i  in  NMaster x AddrWidth  per-master address.
- m_we_i  in  NMaster  per-master write enable.
- m_be_i  in  NMaster x DataWidth/8  per-master byte enables.
- m_wdata_i  in  NMaster x DataWidth  per-master write data.
- m_rvalid_o  out  NMaster  per-master response valid.
- m_rdata_o  out  DataWidth  response data, broadcast to all masters.
- s_req_o  out  1  slave req.
- s_gnt_i  in  1  slave gnt.
- s_addr_o  out  AddrWidth  muxed address.
- s_we_o  out  1  muxed write enable.
- s_be_o  out  DataWidth/8  muxed byte enables.
- s_wdata_o  out  DataWidth  muxed write data.
- s_rvalid_i  in  1  slave response valid.
- s_rdata_i  in  DataWidth  slave response data.
- protocol_err_o  out  1  sticky flag: rvalid received with no outstanding transaction.

Behaviour:
- State:
  - rr_q (clog2(NMaster) bits): next highest-priority index. Reset 0.
  - lock_q (1b) and lock_id_q: winner held while its request is ungranted. Reset 0.
  - ID FIFO of depth MaxOutstanding plus cnt_q (0..MaxOutstanding). Reset empty.
  - err_q. Reset 0.
- full = (cnt_q == MaxOutstanding), using the registered count.
- Winner selection:
  - If lock_q, winner = lock_id_q.
  - Otherwise winner = first asserted m_req_i scanning rr_q, rr_q+1, ... modulo NMaster.
- s_req_o = |m_req_i & ~full. While lock_q is set, s_req_o = m_req_i[lock_id_q] & ~full.
- s_addr/we/be/wdata_o = fields of the winner, combinational with zero latency. They are driven to 0 when s_req_o = 0.
- m_gnt_o[w] = s_req_o & s_gnt_i & (w == winner). All other bits are 0.
- Handshake (s_req_o & s_gnt_i):
  - Push winner into the FIFO.
  - rr_q <= (winner+1) mod NMaster.
  - lock_q <= 0.
- s_req_o & ~s_gnt_i: lock_q <= 1 and lock_id_q <= winner. Other masters cannot preempt.
- Locked master drops req without gnt (protocol violation): lock_q clears the next cycle with no error flagged.
- Response path:
  - s_rvalid_i with cnt_q > 0: m_rvalid_o[fifo head] = 1 in the same cycle, then pop.
  - m_rdata_o = s_rdata_i always.
- s_rvalid_i with cnt_q == 0: no m_rvalid_o asserted, err_q <= 1 (sticky until reset). protocol_err_o = err_q.
- Push and pop in the same cycle: cnt_q unchanged, FIFO order preserved.
- When full, no new grant occurs even if a pop happens in the same cycle (one-cycle bubble, by design).
- The slave must not return rvalid in the same cycle as the gnt of the same transaction (minimum 1-cycle response latency). A same-cycle rvalid belongs to an older entry.
- Reset mid-operation: FIFO, lock and rr_q are cleared; in-flight responses are lost. Masters are reset together with the arbiter.

Optional Feature:
- Macro: GR_HEEP_EXT_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt_o (32b), reset 0.
  - Increments (saturating at 2^32-1) each cycle in which any m_req_i is high and no m_gnt_o bit is high.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- gr_heep_pkg holds:
  - ExtArbNMaster and ExtArbMaxOutstanding localparams.
  - An obi_req_t / obi_resp_t typedef pair parametrised on 32-bit address and data, for crossbar integration.
- One natural sub-module: ext_obi_arb_id_fifo.
  - Synchronous FIFO of clog2(NMaster)-bit IDs with push, pop, head, full, empty and cnt outputs.
  - Synchronous active-high reset.

Test Plan:
- Both masters request continuously, s_gnt_i=1, rvalid 1 cycle later -> grants alternate M0,M1,M0,M1. Each rvalid goes to the matching master; rdata 0xA5A5_0000+n is returned in order.
- M1 requests alone at addr 0x2000_0004 with s_gnt_i=0 for 3 cycles; M0 requests in cycle 1 -> s_addr_o stays 0x2000_0004 and M1 is granted in cycle 3. M0 is granted next.
- MaxOutstanding=2: two grants with no rvalid -> s_req_o=0 while full. One rvalid -> s_req_o reasserts the following cycle.
- Gnt of one transaction in the same cycle as rvalid of an older one with cnt=1 -> cnt stays 1 and the rvalid routes to the older master ID.
- s_rvalid_i pulse with the FIFO empty -> no m_rvalid_o bit set, protocol_err_o=1 from the next cycle until rst_i.
- rst_i asserted with 2 outstanding -> next cycle cnt=0, rr_q=0, lock cleared, protocol_err_o=0. With the stats macro defined, stall_cnt_o=0.

Source files
------------

// File: rtl/gr_heep_pkg.sv
// Shared definitions for the external OBI round-robin arbiter.
// Optional build macro: GR_HEEP_EXT_ARB_STATS_EN (adds a stall counter port).
package gr_heep_pkg;

  localparam int unsigned ExtArbNMaster        = 2;
  localparam int unsigned ExtArbMaxOutstanding = 2;

  // OBI request/response bundle for crossbar integration (32-bit addr/data).
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

  // Width of an index into n items; never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ext_obi_arb_id_fifo.sv
// In-order queue of granted master IDs; head tells which master owns the
// next response. Push/pop in the same cycle keeps the count unchanged.
module ext_obi_arb_id_fifo
  import gr_heep_pkg::*;
#(
  parameter int unsigned IdW   = 1,
  parameter int unsigned Depth = 2,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic [IdW-1:0]  id_i,
  input  logic            pop_i,
  output logic [IdW-1:0]  head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] cnt_o
);

  localparam int unsigned PtrW = idx_width(Depth);

  logic [IdW-1:0]  mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign head_o  = mem_q[rptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Next-state for pointers and occupancy count.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + 1'b1;
    if (do_pop)  rptr_d = (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  // Control state with reset; storage itself needs none.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // ID storage written on accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= id_i;
  end

endmodule

// File: rtl/ext_obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI slave port among NMaster masters.
// The selected master stays locked until granted so its address phase is
// stable; granted IDs are queued to route responses back in order.
// Optional build macro: GR_HEEP_EXT_ARB_STATS_EN adds stall_cnt_o.
module ext_obi_rr_arbiter
  import gr_heep_pkg::*;
#(
  parameter int unsigned NMaster        = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NMaster-1:0]             m_req_i,
  output logic [NMaster-1:0]             m_gnt_o,
  input  logic [NMaster*AddrWidth-1:0]   m_addr_i,
  input  logic [NMaster-1:0]             m_we_i,
  input  logic [NMaster*DataWidth/8-1:0] m_be_i,
  input  logic [NMaster*DataWidth-1:0]   m_wdata_i,
  output logic [NMaster-1:0]             m_rvalid_o,
  output logic [DataWidth-1:0]           m_rdata_o,
  output logic                           s_req_o,
  input  logic                           s_gnt_i,
  output logic [AddrWidth-1:0]           s_addr_o,
  output logic                           s_we_o,
  output logic [DataWidth/8-1:0]         s_be_o,
  output logic [DataWidth-1:0]           s_wdata_o,
  input  logic                           s_rvalid_i,
  input  logic [DataWidth-1:0]           s_rdata_i,
`ifdef GR_HEEP_EXT_ARB_STATS_EN
  output logic [31:0]                    stall_cnt_o,
`endif
  output logic                           protocol_err_o
);

  localparam int unsigned IdW  = idx_width(NMaster);
  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdW-1:0]  rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [IdW-1:0]  lock_id_q, lock_id_d;
  logic            err_q, err_d;

  logic [IdW-1:0]  winner;
  logic            hs;
  logic            full, empty;
  logic [IdW-1:0]  head;
  logic [CntW-1:0] cnt;
  logic            pop;

  ext_obi_arb_id_fifo #(
    .IdW   (IdW),
    .Depth (MaxOutstanding),
    .CntW  (CntW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .id_i    (winner),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .cnt_o   (cnt)
  );

  // Winner: locked master, else first requester scanning from rr_q.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx    = 0;
    found  = 1'b0;
    winner = rr_q;
    if (lock_q) begin
      winner = lock_id_q;
    end else begin
      for (int unsigned i = 0; i < NMaster; i++) begin
        idx = (int'(rr_q) + i) % NMaster;
        if (!found && m_req_i[idx]) begin
          winner = IdW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  assign s_req_o = lock_q ? (m_req_i[lock_id_q] & ~full) : ((|m_req_i) & ~full);
  assign hs      = s_req_o & s_gnt_i;
  assign pop     = s_rvalid_i & ~empty;

  // Zero-latency mux of the winner's address-phase fields; idle bus reads 0.
  always_comb begin
    s_addr_o  = '0;
    s_we_o    = 1'b0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (s_req_o) begin
      s_addr_o  = m_addr_i[int'(winner)*AddrWidth +: AddrWidth];
      s_we_o    = m_we_i[winner];
      s_be_o    = m_be_i[int'(winner)*BeW +: BeW];
      s_wdata_o = m_wdata_i[int'(winner)*DataWidth +: DataWidth];
    end
  end

  // Grant and response demux; rdata is broadcast.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    if (hs)  m_gnt_o[winner]  = 1'b1;
    if (pop) m_rvalid_o[head] = 1'b1;
  end

  assign m_rdata_o = s_rdata_i;

  // Next state for rotation pointer, lock and sticky error.
  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (s_rvalid_i & empty);
    if (hs) begin
      rr_d   = (winner == IdW'(NMaster - 1)) ? '0 : winner + 1'b1;
      lock_d = 1'b0;
    end else if (s_req_o) begin
      lock_d    = 1'b1;
      lock_id_d = winner;
    end else if (lock_q && !m_req_i[lock_id_q]) begin
      // Locked master withdrew without a grant: release silently.
      lock_d = 1'b0;
    end
  end

  // Arbiter control registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  assign protocol_err_o = err_q;

`ifdef GR_HEEP_EXT_ARB_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|m_req_i) && !(|m_gnt_o) && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Saturating count of cycles with a pending request but no grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ext_obi_rr_arbiter.sv
// Directed bench for ext_obi_rr_arbiter (NMaster=2, MaxOutstanding=2).
// Optional build macro: GR_HEEP_EXT_ARB_STATS_EN.
module tb_ext_obi_rr_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  m_req_i;
  logic [1:0]  m_gnt_o;
  logic [63:0] m_addr_i;
  logic [1:0]  m_we_i;
  logic [7:0]  m_be_i;
  logic [63:0] m_wdata_i;
  logic [1:0]  m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        s_req_o;
  logic        s_gnt_i;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;
  logic        protocol_err_o;
`ifdef GR_HEEP_EXT_ARB_STATS_EN
  logic [31:0] stall_cnt_o;
`endif

  int nvec = 0;
  int nerr = 0;

  localparam logic [31:0] A0 = 32'h2000_0000;
  localparam logic [31:0] A1 = 32'h2000_0004;

  ext_obi_rr_arbiter #(
    .NMaster(2), .MaxOutstanding(2), .AddrWidth(32), .DataWidth(32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .m_req_i        (m_req_i),
    .m_gnt_o        (m_gnt_o),
    .m_addr_i       (m_addr_i),
    .m_we_i         (m_we_i),
    .m_be_i         (m_be_i),
    .m_wdata_i      (m_wdata_i),
    .m_rvalid_o     (m_rvalid_o),
    .m_rdata_o      (m_rdata_o),
    .s_req_o        (s_req_o),
    .s_gnt_i        (s_gnt_i),
    .s_addr_o       (s_addr_o),
    .s_we_o         (s_we_o),
    .s_be_o         (s_be_o),
    .s_wdata_o      (s_wdata_o),
    .s_rvalid_i     (s_rvalid_i),
    .s_rdata_i      (s_rdata_i),
`ifdef GR_HEEP_EXT_ARB_STATS_EN
    .stall_cnt_o    (stall_cnt_o),
`endif
    .protocol_err_o (protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are then driven 1ns after the edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Apply inputs and let combinational outputs settle before checking.
  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rd);
    m_req_i    = req;
    s_gnt_i    = gnt;
    s_rvalid_i = rv;
    s_rdata_i  = rd;
    #1;
  endtask

  initial begin
    m_addr_i   = {A1, A0};
    m_we_i     = 2'b01;
    m_be_i     = {4'h3, 4'hF};
    m_wdata_i  = {32'h2222_0000, 32'h1111_0000};
    m_req_i    = '0;
    s_gnt_i    = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;
    rst_i      = 1'b1;
    repeat (2) cyc();
    rst_i = 1'b0;

    // Reset state
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("rst_err",  protocol_err_o, 1'b0);
    chk("rst_sreq", s_req_o,        1'b0);
    chk("rst_addr", s_addr_o,       32'h0);
    chk("rst_gnt",  m_gnt_o,        2'b00);
`ifdef GR_HEEP_EXT_ARB_STATS_EN
    chk("rst_stall", stall_cnt_o, 32'd0);
`endif

    // Both masters request continuously, slave answers one cycle later
    for (int n = 0; n < 4; n++) begin
      cyc();
      drive(2'b11, 1'b1, n > 0, 32'hA5A5_0000 + n - 1);
      chk("alt_gnt",  m_gnt_o, (n % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_addr", s_addr_o, (n % 2 == 0) ? A0 : A1);
      chk("alt_rv",   m_rvalid_o, (n == 0) ? 2'b00 : (((n - 1) % 2 == 0) ? 2'b01 : 2'b10));
      if (n > 0) chk("alt_rd", m_rdata_o, 32'hA5A5_0000 + n - 1);
    end
    cyc();
    drive(2'b00, 1'b0, 1'b1, 32'hA5A5_0003);
    chk("alt_rv_last", m_rvalid_o, 2'b10);
    chk("alt_rd_last", m_rdata_o,  32'hA5A5_0003);

    // M1 alone, stalled by slave; M0 joins but must not preempt
    cyc();
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    chk("lk0_sreq", s_req_o, 1'b1);
    chk("lk0_addr", s_addr_o, A1);
    chk("lk0_we",   s_we_o, 1'b0);
    chk("lk0_be",   s_be_o, 4'h3);
    for (int c = 1; c < 3; c++) begin
      cyc();
      drive(2'b11, 1'b0, 1'b0, 32'h0);
      chk("lk_addr", s_addr_o, A1);
      chk("lk_gnt",  m_gnt_o, 2'b00);
    end
    cyc();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("lk3_gnt",  m_gnt_o, 2'b10);
    chk("lk3_addr", s_addr_o, A1);
    cyc();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    chk("lk4_gnt",   m_gnt_o, 2'b01);
    chk("lk4_addr",  s_addr_o, A0);
    chk("lk4_wdata", s_wdata_o, 32'h1111_0000);

    // Two outstanding: full, no request forwarded
    cyc();
    drive(2'b11, 1'b1, 1'b0, 32'h0);
    chk("full_sreq", s_req_o, 1'b0);
    chk("full_gnt",  m_gnt_o, 2'b00);
    chk("full_addr", s_addr_o, 32'h0);
    cyc();
    drive(2'b11, 1'b1, 1'b1, 32'h0000_00B1);
    chk("full_pop_sreq", s_req_o, 1'b0);
    chk("full_pop_rv",   m_rvalid_o, 2'b10);

    // Request reasserts; same-cycle grant and older response (cnt stays 1)
    cyc();
    drive(2'b11, 1'b1, 1'b1, 32'h0000_00B0);
    chk("pp_sreq", s_req_o, 1'b1);
    chk("pp_gnt",  m_gnt_o, 2'b10);
    chk("pp_rv",   m_rvalid_o, 2'b01);
    cyc();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_00B2);
    chk("pp_rv2", m_rvalid_o, 2'b10);

    // Response with nothing outstanding
    cyc();
    drive(2'b00, 1'b0, 1'b1, 32'h0);
    chk("orph_rv",  m_rvalid_o, 2'b00);
    chk("orph_err0", protocol_err_o, 1'b0);
    cyc();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("orph_err1", protocol_err_o, 1'b1);
    cyc();
    chk("orph_err2", protocol_err_o, 1'b1);

    // Fill with two M0 grants (leaves rr pointing at M1), then reset
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    chk("fill0_gnt", m_gnt_o, 2'b01);
    cyc();
    drive(2'b01, 1'b1, 1'b0, 32'h0);
    chk("fill1_gnt", m_gnt_o, 2'b01);
    cyc();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("fill_sreq", s_req_o, 1'b0);
    chk("fill_err",  protocol_err_o, 1'b1);
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("rst2_err",  protocol_err_o, 1'b0);
    chk("rst2_sreq", s_req_o, 1'b1);
    chk("rst2_addr", s_addr_o, A0);
`ifdef GR_HEEP_EXT_ARB_STATS_EN
    chk("rst2_stall", stall_cnt_o, 32'd0);
`endif
    cyc();
    drive(2'b11, 1'b0, 1'b0, 32'h0);
    chk("rst2_lock_addr", s_addr_o, A0);
`ifdef GR_HEEP_EXT_ARB_STATS_EN
    chk("stall_one", stall_cnt_o, 32'd1);
`endif

    // Locked M0 withdraws without grant: lock released next cycle
    cyc();
    drive(2'b10, 1'b0, 1'b0, 32'h0);
    chk("drop_sreq", s_req_o, 1'b0);
    cyc();
    drive(2'b10, 1'b1, 1'b0, 32'h0);
    chk("drop_next_gnt",  m_gnt_o, 2'b10);
    chk("drop_next_addr", s_addr_o, A1);
    cyc();
    drive(2'b00, 1'b0, 1'b1, 32'h0000_00C1);
    chk("post_rst_rv",  m_rvalid_o, 2'b10);
    cyc();
    drive(2'b00, 1'b0, 1'b0, 32'h0);
    chk("post_rst_err", protocol_err_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1);
  end

endmodule
